imem_loader: RTL and testbench

- Writer side of the 512-word instruction memory: it fills the memory before the core starts fetching.
- Accepts a byte stream from the boot link (UART/debug bridge) over a valid/ready handshake.
- Parses a length header, packs bytes into 32-bit words and issues single-cycle writes to the memory write port.
- Holds the core in reset (cpu_hold) until the image is complete and error-free.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_word_packer.sv | 51 +++++
 rtl/imem_loader.sv | 219 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// The IMEM_LOADER_CHECKSUM_EN macro (see imem_loader.sv) enables the CHK state.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_LENGTH   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH  = 512;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Collects four stream bytes into one 32-bit word; word_o already includes the
// byte being accepted so the parent can register the finished word on that edge.
module word_packer
  import imem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;

  // Big-endian shifts left so the first byte ends in [31:24]; little-endian
  // shifts right so the first byte ends in [7:0].
  always_comb begin
    if (BIG_ENDIAN) begin
      word_o = {shift_q[23:0], byte_i};
    end else begin
      word_o = {byte_i, shift_q[31:8]};
    end
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear_i) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      idx_d   = idx_q + 2'd1;
      shift_d = word_o;
    end
  end

  assign word_complete_o = byte_valid_i && (idx_q == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader that fills the instruction memory from a byte stream and holds the
// core in reset until the image is complete. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          DEPTH       = DEF_DEPTH,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded,
  output logic              cpu_hold
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 2);

  loader_state_e     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic              accept;
  logic              data_accept;
  logic              start_ok;
  logic              timeout_hit;
  logic [15:0]       hdr_n;
  logic [ADDR_W:0]   words_inc;
  logic [TO_W-1:0]   to_cnt_inc;
  logic [31:0]       packed_word;
  logic              word_complete;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif

  assign in_ready    = state_q inside {ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CHK};
  assign busy        = in_ready;
  assign done        = (state_q == ST_DONE);
  assign err         = (state_q == ST_ERR);
  assign accept      = in_valid && in_ready;
  assign data_accept = accept && (state_q == ST_DATA);
  assign start_ok    = start && !busy;
  assign hdr_n       = {len_q[15:8], in_data};
  assign words_inc   = words_q + 1'b1;
  assign to_cnt_inc  = to_cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYC != 0) && in_ready && !accept &&
                       (to_cnt_inc == TO_W'(TIMEOUT_CYC));

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign err_code     = err_code_q;
  assign words_loaded = words_q;
  assign cpu_hold     = cpu_hold_q;

  word_packer #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_packer (
    .clk            (clk),
    .reset          (reset),
    .clear_i        (start_ok),
    .byte_valid_i   (data_accept),
    .byte_i         (in_data),
    .word_o         (packed_word),
    .word_complete_o(word_complete)
  );

  // Next-state logic; a timeout only fires on a cycle without an accepted byte,
  // so a byte arriving on the deadline edge still wins.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    words_d    = words_q;
    to_cnt_d   = '0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_code_d = err_code_q;
    cpu_hold_d = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    if (in_ready && !accept) begin
      to_cnt_d = to_cnt_inc;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HDR_HI;
          len_d      = '0;
          words_d    = '0;
          err_code_d = ERR_NONE;
          cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = '0;
`endif
        end else if (state_q == ST_DONE) begin
          cpu_hold_d = 1'b0;
        end
      end
      ST_HDR_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (accept) begin
          len_d = hdr_n;
          if (hdr_n == 16'd0) begin
            state_d = ST_DONE;
          end else if (int'(hdr_n) > DEPTH) begin
            state_d    = ST_ERR;
            err_code_d = ERR_LENGTH;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) begin
          chk_d = chk_q ^ in_data;
        end
`endif
        if (word_complete) begin
          wr_en_d   = 1'b1;
          wr_addr_d = words_q[ADDR_W-1:0];
          wr_data_d = packed_word;
          words_d   = words_inc;
          if (16'(words_inc) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) begin
          if (in_data == chk_q) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_CHECKSUM;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (timeout_hit) begin
      state_d    = ST_ERR;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      words_q    <= '0;
      to_cnt_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_code_q <= ERR_NONE;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      words_q    <= words_d;
      to_cnt_q   <= to_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_code_q <= err_code_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a big-endian and a little-endian instance
// share one stimulus stream and are compared against a byte-image model.
module tb_imem_loader;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int TO     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, in_valid;
  logic [7:0] in_data;

  logic              rdy_be, wen_be, busy_be, done_be, err_be, hold_be;
  logic [ADDR_W-1:0] wa_be;
  logic [31:0]       wd_be;
  logic [1:0]        ec_be;
  logic [ADDR_W:0]   wl_be;
  logic              rdy_le, wen_le, busy_le, done_le, err_le, hold_le;
  logic [ADDR_W-1:0] wa_le;
  logic [31:0]       wd_le;
  logic [1:0]        ec_le;
  logic [ADDR_W:0]   wl_le;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(TO)) dut_be (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_be), .wr_en(wen_be), .wr_addr(wa_be), .wr_data(wd_be), .busy(busy_be),
    .done(done_be), .err(err_be), .err_code(ec_be), .words_loaded(wl_be), .cpu_hold(hold_be));

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BIG_ENDIAN(1'b0), .TIMEOUT_CYC(TO)) dut_le (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_le), .wr_en(wen_le), .wr_addr(wa_le), .wr_data(wd_le), .busy(busy_le),
    .done(done_le), .err(err_le), .err_code(ec_le), .words_loaded(wl_le), .cpu_hold(hold_le));

  int checks = 0;
  int passed = 0;

  logic [7:0]  img [0:2047];
  int          wab_log[$], wal_log[$];
  logic [31:0] wdb_log[$], wdl_log[$];

  // Every cycle with wr_en high is one memory write.
  always @(negedge clk) begin
    if (wen_be) begin wab_log.push_back(int'(wa_be)); wdb_log.push_back(wd_be); end
    if (wen_le) begin wal_log.push_back(int'(wa_le)); wdl_log.push_back(wd_le); end
  end

  function automatic logic [31:0] exp_word(input int i, input bit be);
    logic [7:0] b0, b1, b2, b3;
    b0 = img[4*i]; b1 = img[4*i+1]; b2 = img[4*i+2]; b3 = img[4*i+3];
    return be ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
  endfunction

  function automatic logic [7:0] xor_of(input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 4*n; i++) x ^= img[i];
    return x;
  endfunction

  task automatic clear_logs();
    wab_log.delete(); wal_log.delete(); wdb_log.delete(); wdl_log.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap, output bit ok);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      if (rdy_be) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_load(input int n, input int maxgap, output bit ok);
    bit b;
    ok = 1'b1;
    send_byte(8'(n >> 8), maxgap, b); ok &= b;
    send_byte(8'(n), maxgap, b);      ok &= b;
    for (int i = 0; i < 4*n && ok; i++) begin
      send_byte(img[i], maxgap, b); ok &= b;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (ok) begin send_byte(xor_of(n), maxgap, b); ok &= b; end
`endif
  endtask

  task automatic wait_end(input int maxcyc);
    for (int t = 0; t < maxcyc; t++) begin
      if (done_be || err_be) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (rdy_be !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b want 0", rdy_be); else passed++;
    checks++; if (wen_be !== 1'b0) $display("[TB] FAIL reset_wr_en: got %b want 0", wen_be); else passed++;
    checks++; if (busy_be !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy_be); else passed++;
    checks++; if (done_be !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done_be); else passed++;
    checks++; if (err_be !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err_be); else passed++;
    checks++; if (ec_be !== 2'd0) $display("[TB] FAIL reset_err_code: got %0d want 0", ec_be); else passed++;
    checks++; if (wl_be !== '0) $display("[TB] FAIL reset_words_loaded: got %0d want 0", wl_be); else passed++;
    checks++; if ({wa_be, wd_be} !== '0) $display("[TB] FAIL reset_wr_bus: got %h/%h want 0/0", wa_be, wd_be); else passed++;
    checks++; if (hold_be !== 1'b1 || hold_le !== 1'b1) $display("[TB] FAIL reset_cpu_hold: got %b%b want 11", hold_be, hold_le); else passed++;
  endtask

  task automatic test_basic_load();
    bit ok;
    logic [7:0] s [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 8; i++) img[i] = s[i];
    clear_logs();
    pulse_start();
    checks++; if (busy_be !== 1'b1 || hold_be !== 1'b1) $display("[TB] FAIL basic_busy_after_start: got busy=%b hold=%b want 1/1", busy_be, hold_be); else passed++;
    send_load(2, 0, ok);
    checks++; if (!ok) $display("[TB] FAIL basic_stream_accepted: got stalled want accepted"); else passed++;
    wait_end(20);
    checks++; if (done_be !== 1'b1 || hold_be !== 1'b1) $display("[TB] FAIL basic_done_rise: got done=%b hold=%b want 1/1", done_be, hold_be); else passed++;
    @(negedge clk);
    checks++; if (hold_be !== 1'b0 || done_be !== 1'b1) $display("[TB] FAIL basic_hold_fall: got hold=%b done=%b want 0/1", hold_be, done_be); else passed++;
    checks++; if (wl_be !== 10'd2 || busy_be !== 1'b0) $display("[TB] FAIL basic_words_loaded: got %0d busy=%b want 2/0", wl_be, busy_be); else passed++;
    checks++; if (wdb_log.size() != 2 || wdl_log.size() != 2) $display("[TB] FAIL basic_write_count: got %0d/%0d want 2/2", wdb_log.size(), wdl_log.size());
    else begin
      passed++;
      checks++; if (wab_log[0] != 0 || wdb_log[0] !== 32'h12345678) $display("[TB] FAIL basic_be_word0: got %0d:%h want 0:12345678", wab_log[0], wdb_log[0]); else passed++;
      checks++; if (wab_log[1] != 1 || wdb_log[1] !== 32'hAABBCCDD) $display("[TB] FAIL basic_be_word1: got %0d:%h want 1:aabbccdd", wab_log[1], wdb_log[1]); else passed++;
      checks++; if (wal_log[0] != 0 || wdl_log[0] !== 32'h78563412) $display("[TB] FAIL basic_le_word0: got %0d:%h want 0:78563412", wal_log[0], wdl_log[0]); else passed++;
      checks++; if (wal_log[1] != 1 || wdl_log[1] !== 32'hDDCCBBAA) $display("[TB] FAIL basic_le_word1: got %0d:%h want 1:ddccbbaa", wal_log[1], wdl_log[1]); else passed++;
    end
  endtask

  task automatic test_random_loads();
    bit ok;
    int n, bad;
    for (int it = 0; it < 5; it++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < 4*n; i++) img[i] = 8'($urandom);
      clear_logs();
      pulse_start();
      send_load(n, 3, ok);
      wait_end(20);
      @(negedge clk);
      checks++; if (!ok || done_be !== 1'b1 || err_be !== 1'b0) $display("[TB] FAIL rand_done it%0d: got ok=%b done=%b err=%b want 1/1/0", it, ok, done_be, err_be); else passed++;
      checks++; if (int'(wl_be) != n || int'(wl_le) != n) $display("[TB] FAIL rand_words_loaded it%0d: got %0d/%0d want %0d", it, wl_be, wl_le, n); else passed++;
      bad = 0;
      if (wdb_log.size() != n || wdl_log.size() != n) bad = 1000;
      else for (int i = 0; i < n; i++) begin
        if (wab_log[i] != i || wdb_log[i] !== exp_word(i, 1'b1)) bad++;
        if (wal_log[i] != i || wdl_log[i] !== exp_word(i, 1'b0)) bad++;
      end
      checks++; if (bad != 0) $display("[TB] FAIL rand_writes it%0d: got %0d bad writes (count %0d) want 0 of %0d", it, bad, wdb_log.size(), n); else passed++;
    end
  endtask

  task automatic test_length_bounds();
    bit ok, b;
    int bad;
    // Zero-length image completes with no writes.
    clear_logs();
    pulse_start();
    send_load(0, 2, ok);
    wait_end(20);
    @(negedge clk);
    checks++; if (done_be !== 1'b1 || wl_be !== '0 || wdb_log.size() != 0) $display("[TB] FAIL len0: got done=%b words=%0d writes=%0d want 1/0/0", done_be, wl_be, wdb_log.size()); else passed++;
    // Exactly DEPTH words fills the whole memory.
    for (int i = 0; i < 4*DEPTH; i++) img[i] = 8'($urandom);
    clear_logs();
    pulse_start();
    send_load(DEPTH, 0, ok);
    wait_end(20);
    @(negedge clk);
    bad = 0;
    if (wdb_log.size() != DEPTH || wdl_log.size() != DEPTH) bad = 100000;
    else for (int i = 0; i < DEPTH; i++) begin
      if (wab_log[i] != i || wdb_log[i] !== exp_word(i, 1'b1)) bad++;
      if (wal_log[i] != i || wdl_log[i] !== exp_word(i, 1'b0)) bad++;
    end
    checks++; if (!ok || done_be !== 1'b1 || bad != 0) $display("[TB] FAIL len512: got ok=%b done=%b bad=%0d want 1/1/0", ok, done_be, bad); else passed++;
    checks++; if (int'(wl_be) != DEPTH) $display("[TB] FAIL len512_words: got %0d want %0d", wl_be, DEPTH); else passed++;
    // DEPTH+1 is rejected right after the header.
    clear_logs();
    pulse_start();
    send_byte(8'h02, 0, b);
    send_byte(8'h01, 0, b);
    @(negedge clk);
    checks++; if (err_be !== 1'b1 || ec_be !== 2'd1) $display("[TB] FAIL len513_err: got err=%b code=%0d want 1/1", err_be, ec_be); else passed++;
    checks++; if (hold_be !== 1'b1 || busy_be !== 1'b0 || rdy_be !== 1'b0) $display("[TB] FAIL len513_state: got hold=%b busy=%b rdy=%b want 1/0/0", hold_be, busy_be, rdy_be); else passed++;
    send_byte(8'h55, 0, b);
    checks++; if (b || wdb_log.size() != 0) $display("[TB] FAIL len513_no_write: got accepted=%b writes=%0d want 0/0", b, wdb_log.size()); else passed++;
  endtask

  task automatic test_timeout();
    bit b;
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0, b);
    send_byte(8'h01, 0, b);
    send_byte(8'h9C, 0, b);
    repeat (TO - 1) @(negedge clk);
    checks++; if (err_be !== 1'b0) $display("[TB] FAIL timeout_early: got err=%b want 0", err_be); else passed++;
    @(negedge clk);
    checks++; if (err_be !== 1'b1 || ec_be !== 2'd2) $display("[TB] FAIL timeout_err: got err=%b code=%0d want 1/2", err_be, ec_be); else passed++;
    checks++; if (wdb_log.size() != 0 || hold_be !== 1'b1) $display("[TB] FAIL timeout_no_write: got writes=%0d hold=%b want 0/1", wdb_log.size(), hold_be); else passed++;
  endtask

  task automatic test_reset_midload();
    bit ok, b;
    int bad;
    for (int i = 0; i < 12; i++) img[i] = 8'($urandom);
    clear_logs();
    pulse_start();
    send_byte(8'h00, 2, b);
    send_byte(8'h03, 2, b);
    for (int i = 0; i < 8; i++) send_byte(img[i], 3, b);
    @(negedge clk);
    checks++; if (wdb_log.size() != 2) $display("[TB] FAIL midload_pre_writes: got %0d want 2", wdb_log.size()); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (wen_be !== 1'b0 || busy_be !== 1'b0 || hold_be !== 1'b1 || wl_be !== '0 || ec_be !== 2'd0) $display("[TB] FAIL midload_reset_outputs: got wen=%b busy=%b hold=%b words=%0d code=%0d want 0/0/1/0/0", wen_be, busy_be, hold_be, wl_be, ec_be); else passed++;
    reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin in_data = img[8 + (i % 4)]; @(negedge clk); end
    in_valid = 1'b0;
    checks++; if (wdb_log.size() != 2 || done_be !== 1'b0) $display("[TB] FAIL midload_no_more_writes: got %0d done=%b want 2/0", wdb_log.size(), done_be); else passed++;
    for (int i = 0; i < 12; i++) img[i] = 8'($urandom);
    clear_logs();
    pulse_start();
    send_load(3, 3, ok);
    wait_end(20);
    @(negedge clk);
    bad = 0;
    if (wdb_log.size() != 3 || wdl_log.size() != 3) bad = 100;
    else for (int i = 0; i < 3; i++) begin
      if (wab_log[i] != i || wdb_log[i] !== exp_word(i, 1'b1)) bad++;
      if (wal_log[i] != i || wdl_log[i] !== exp_word(i, 1'b0)) bad++;
    end
    checks++; if (!ok || done_be !== 1'b1 || bad != 0) $display("[TB] FAIL midload_reload: got ok=%b done=%b bad=%0d want 1/1/0", ok, done_be, bad); else passed++;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit b;
    logic [7:0] s [7];
    for (int pass = 0; pass < 2; pass++) begin
      s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, (pass == 0) ? 8'h04 : 8'h05};
      clear_logs();
      pulse_start();
      for (int i = 0; i < 7; i++) send_byte(s[i], 1, b);
      @(negedge clk);
      checks++; if (wdb_log.size() != 1 || wdb_log[0] !== 32'h01020304) $display("[TB] FAIL chk_write p%0d: got %0d writes want 1 of 01020304", pass, wdb_log.size()); else passed++;
      if (pass == 0) begin
        checks++; if (done_be !== 1'b1 || hold_be !== 1'b0) $display("[TB] FAIL chk_match: got done=%b hold=%b want 1/0", done_be, hold_be); else passed++;
      end else begin
        checks++; if (err_be !== 1'b1 || ec_be !== 2'd3 || hold_be !== 1'b1) $display("[TB] FAIL chk_mismatch: got err=%b code=%0d hold=%b want 1/3/1", err_be, ec_be, hold_be); else passed++;
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_random_loads();
    test_length_bounds();
    test_timeout();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
